// File: rtl/fifo_sync_ctrl_if.sv
// Handshake, address and status bundle between the FIFO controller and its clients/fifomem.
// master = producer/consumer side, slave = controller side.
interface fifo_sync_ctrl_if #(
    parameter int address_Size = 5
);
    logic                    flush;
    logic                    wr_Req;
    logic                    rd_Req;
    logic                    w_Enable;
    logic [address_Size-1:0] w_Addr;
    logic [address_Size-1:0] r_Addr;
    logic                    fifo_Full;
    logic                    fifo_Empty;
    logic                    almost_Full;
    logic                    almost_Empty;
    logic [address_Size:0]   fill_Count;
    logic                    overflow_Err;
    logic                    underflow_Err;

    modport slave (
        input  flush, wr_Req, rd_Req,
        output w_Enable, w_Addr, r_Addr, fifo_Full, fifo_Empty,
               almost_Full, almost_Empty, fill_Count, overflow_Err, underflow_Err
    );

    modport master (
        output flush, wr_Req, rd_Req,
        input  w_Enable, w_Addr, r_Addr, fifo_Full, fifo_Empty,
               almost_Full, almost_Empty, fill_Count, overflow_Err, underflow_Err
    );
endinterface

// File: rtl/fifo_sync_ctrl.sv
// Single-clock first-word-fall-through FIFO controller: owns the fifomem pointers
// and derives all status from registered pointer state.
module fifo_sync_ctrl #(
    parameter int address_Size = 5,
    parameter int af_Margin    = 2,
    parameter int ae_Margin    = 2
) (
    input logic               w_Clk,
    input logic               w_Rst,
    fifo_sync_ctrl_if.slave   bus
);
    localparam int DEPTH = 1 << address_Size;
    localparam logic [address_Size:0] AF_LVL = (address_Size+1)'(DEPTH - af_Margin);
    localparam logic [address_Size:0] AE_LVL = (address_Size+1)'(ae_Margin);

    logic [address_Size:0] wptr, rptr, fill;
    logic                  full, empty, push, pop;
    logic                  ovf_q, udf_q;

    // Extra MSB on each pointer distinguishes full from empty when the address bits match.
    assign empty = (wptr == rptr);
    assign full  = (wptr[address_Size-1:0] == rptr[address_Size-1:0]) &&
                   (wptr[address_Size] != rptr[address_Size]);
    assign fill  = wptr - rptr;

    assign push = bus.wr_Req & ~full  & ~bus.flush;
    assign pop  = bus.rd_Req & ~empty & ~bus.flush;

    always_ff @(posedge w_Clk) begin
        if (w_Rst) begin
            wptr  <= '0;
            rptr  <= '0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (bus.flush) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (bus.wr_Req & full)  ovf_q <= 1'b1;
            if (bus.rd_Req & empty) udf_q <= 1'b1;
        end
    end

    assign bus.w_Enable      = push;
    assign bus.w_Addr        = wptr[address_Size-1:0];
    assign bus.r_Addr        = rptr[address_Size-1:0];
    assign bus.fifo_Full     = full;
    assign bus.fifo_Empty    = empty;
    assign bus.fill_Count    = fill;
    assign bus.almost_Full   = (fill >= AF_LVL);
    assign bus.almost_Empty  = (fill <= AE_LVL);
    assign bus.overflow_Err  = ovf_q;
    assign bus.underflow_Err = udf_q;

    always_ff @(posedge w_Clk)
        assert (af_Margin < DEPTH && ae_Margin < DEPTH)
            else $error("fifo_sync_ctrl: af_Margin/ae_Margin must be below DEPTH");
endmodule

// File: doc/fifo_sync_ctrl.md
Name: fifo_sync_ctrl

Overview:
- Single-clock controller sequencing the fifomem dual-port array as a synchronous first-word-fall-through FIFO.
- Owns the write and read pointers and drives w_Addr, r_Addr, w_Enable and fifo_Full into fifomem.
- Exports empty/full/almost/level status and sticky error flags to the producer and consumer.
- Data does not pass through this block: write_Data and read_Data connect directly between the clients and fifomem.

Parameters:
address_Size, 5, pointer/address width; DEPTH = 1<<address_Size entries
af_Margin, 2, almost_Full asserts when fill_Count >= DEPTH - af_Margin
ae_Margin, 2, almost_Empty asserts when fill_Count <= ae_Margin

Ports:
w_Clk  input  1  single clock for the whole block and fifomem
w_Rst  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of pointers; highest priority after w_Rst
wr_Req  input  1  producer push request
rd_Req  input  1  consumer pop request (read_Data holds the head entry)
w_Enable  output  1  write strobe to fifomem
w_Addr  output  address_Size  write address to fifomem
r_Addr  output  address_Size  read address to fifomem (head of queue)
fifo_Full  output  1  FIFO holds DEPTH entries
fifo_Empty  output  1  FIFO holds 0 entries
almost_Full  output  1  level at or above the high watermark
almost_Empty  output  1  level at or below the low watermark
fill_Count  output  address_Size+1  current occupancy, 0..DEPTH
overflow_Err  output  1  sticky: push attempted while full
underflow_Err  output  1  sticky: pop attempted while empty

Behaviour:
- Internal pointers: wptr and rptr, each address_Size+1 bits (MSB is the wrap bit). w_Addr and r_Addr are the low address_Size bits of each pointer.
- fifo_Empty = (wptr == rptr).
- fifo_Full = low bits equal and MSBs differ.
- fill_Count = wptr - rptr, modulo 2^(address_Size+1).
- All status outputs decode from registered state only. There is no combinational path from wr_Req or rd_Req to any flag or to fill_Count.
- Push accepted: push = wr_Req & !fifo_Full & !flush.
  - w_Enable = push (combinational).
  - On the edge, wptr increments.
- Pop accepted: pop = rd_Req & !fifo_Empty & !flush.
  - On the edge, rptr increments.
  - read_Data is valid whenever fifo_Empty = 0.
- Simultaneous push and pop:
  - Neither full nor empty: both pointers advance and fill_Count is unchanged.
  - Full: the push is rejected (fifomem also blocks writes while full). The pop proceeds, so fill_Count becomes DEPTH-1.
  - Empty: the pop is rejected. The push proceeds, so fill_Count becomes 1.
- Latency:
  - A push on edge N gives fifo_Empty = 0 after edge N; the data is visible on read_Data in cycle N+1.
  - A pop on edge N advances the head after edge N.
- Wrap-around: pointers roll from 2^(address_Size+1)-1 to 0 with no special handling. Full and empty must remain correct across any number of wraps.
- Error flags:
  - overflow_Err is set on any edge where wr_Req & fifo_Full & !flush.
  - underflow_Err is set on any edge where rd_Req & fifo_Empty & !flush.
  - Both clear only on w_Rst (flush does not clear them).
- flush:
  - On the edge, wptr = rptr = 0.
  - w_Enable is forced to 0 during the flush cycle.
  - Requests in that cycle are ignored and do not set error flags.
- w_Rst: on the edge, both pointers and both error flags become 0. Reset state of outputs:
  - fifo_Empty = 1, fifo_Full = 0
  - almost_Empty = 1, almost_Full = 0 (for af_Margin < DEPTH)
  - fill_Count = 0, w_Addr = r_Addr = 0, w_Enable = 0
- Reset mid-operation: contents held in fifomem become don't-care, and no stale entry is presented as valid.
- Parameter legality: af_Margin and ae_Margin must each be less than DEPTH, otherwise the block is illegal (simulation assertion).

Test Plan:
(All with address_Size=3, DEPTH=8, af_Margin=2, ae_Margin=2.)
- Reset, then 8 consecutive pushes of 0x10..0x17 -> fill_Count steps 1..8.
  - almost_Empty drops at count 3; almost_Full rises at count 6.
  - fifo_Full = 1 after the 8th edge; w_Addr follows 0..7.
- From full: a 9th push -> w_Enable = 0, wptr unchanged, overflow_Err = 1 and stays 1.
  - Then 8 pops -> read_Data sequence 0x10..0x17, fifo_Empty = 1 after the 8th pop.
- Continuous simultaneous push and pop at count 4 for 20 cycles -> fill_Count stays 4.
  - Both pointers wrap past 15→0; data order is preserved.
- From empty: rd_Req alone -> underflow_Err = 1, rptr unchanged.
  - Same cycle push + pop on empty -> fill_Count = 1, r_Addr unchanged.
- At count 5: assert flush together with wr_Req -> next cycle fill_Count = 0, fifo_Empty = 1, w_Enable was 0.
  - Error flags keep their prior values.
- At count 3: assert w_Rst for 1 cycle during a push -> all outputs return to reset values on that edge, error flags = 0.
